rr_mux_4x1: RTL and testbench
=============================

RR_MUX_4X1 -- requirements
Module: rr_mux_4x1

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, data width of every input and of the output.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: din  input  4xWIDTH  data for sources 0..3.
REQ-005 SHALL provide port: din_valid  input  4  per-source valid.
REQ-006 SHALL provide port: din_ready  output  4  per-source ready.
REQ-007 SHALL provide port: dout  output  WIDTH  registered merged data.
REQ-008 SHALL provide port: dout_valid  output  1  dout holds an unconsumed word.
REQ-009 SHALL provide port: dout_ready  input  1  downstream accepts dout.
REQ-010 SHALL provide port: dout_sel  output  2  source index of the word in dout; the inverse-direction tag a 1x4 demux consumes.

Function
REQ-011 SHALL transfer input i on a cycle where din_valid[i] and din_ready[i] are both 1; output transfers when dout_valid and dout_ready are both 1.
REQ-012 SHALL use a two-state FSM: EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-013 SHALL define can_load = EMPTY or (FULL and dout_ready).
REQ-014 SHALL compute combinational grant from din_valid and the pointer ptr; din_ready[i] = can_load and grant==i and any din_valid. At most one din_ready bit is high.
REQ-015 SHALL, on an input transfer, load dout<=din[grant] and dout_sel<=grant, with FSM to FULL on the next edge; latency 1 cycle.
REQ-016 SHALL go FULL->EMPTY only on output transfer with no input transfer in the same cycle; simultaneous output and input transfers stay FULL with the new word. This gives full throughput: one word per cycle.
REQ-017 SHALL hold dout and dout_sel stable while FULL and dout_ready=0.
REQ-018 SHALL update ptr<=grant only on an input transfer; ptr is unchanged otherwise.
REQ-019 SHALL drive din_ready all 0 with no input transfer when no din_valid bit is set.
REQ-020 SHALL not guarantee retention of a source's valid that is withdrawn before its transfer; no error is flagged.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force: FSM=EMPTY, dout_valid=0, dout=0, dout_sel=0, ptr=3, din_ready=0.
REQ-022 SHALL discard any held word on reset mid-operation. After release, the first search starts at source 0.

Configuration
REQ-023 SHALL honour macro RR_MUX_ROUND_ROBIN_EN.
REQ-024 SHALL, when RR_MUX_ROUND_ROBIN_EN is defined, grant the first valid source searching ptr+1, ptr+2, ptr+3, ptr (mod 4; wrap 3->0).
REQ-025 SHALL, when RR_MUX_ROUND_ROBIN_EN is undefined, grant the lowest-index valid source (fixed priority). ptr has no effect on grant, and all other behaviour is identical.

Structure
REQ-026 SHALL place in shared package rr_mux_pkg: N_IN=4, sel_t (2-bit), state enum {EMPTY, FULL}, PTR_RST=2'd3.
REQ-027 SHALL implement grant selection in one sub-module rr_arbiter_4 with inputs req[3:0] and ptr and outputs grant and any. It SHALL contain both macro variants.
REQ-028 SHALL be 120-400 lines of RTL in total.

Verification
REQ-029 SHALL verify reset: assert rst_n=0 mid-FULL with dout=8'hA5 -> dout_valid=0, dout=0, dout_sel=0 immediately. After release, with all valid: the first grant is source 0.
REQ-030 SHALL verify single source: din_valid=4'b0100, din[2]=8'h3C, dout_ready=1 -> din_ready=4'b0100; next cycle dout=8'h3C, dout_sel=2, dout_valid=1.
REQ-031 SHALL verify round-robin (macro defined): all valid, dout_ready=1, din[i]=8'h10+i -> dout_sel sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-032 SHALL verify fixed priority (macro undefined): same stimulus as REQ-031 -> dout_sel constant 0 and din_ready=4'b0001 every cycle.
REQ-033 SHALL verify backpressure: FULL with dout=8'h55 and dout_ready=0 for 3 cycles, all valid -> din_ready=0 and dout stable 8'h55. Raise dout_ready -> the 8'h55 transfer and the next grant load occur in the same cycle; dout_valid stays 1.
REQ-034 SHALL verify idle drain: FULL, din_valid=0, dout_ready=1 -> next cycle dout_valid=0 and ptr unchanged.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types and constants for the 4:1 round-robin mux
//
// Purpose : common definitions imported by rr_arbiter_4 and rr_mux_4x1.
//   N_IN    - number of merged sources (4)
//   sel_t   - 2-bit source index type
//   state_t - output-register state {EMPTY, FULL}
//   PTR_RST - pointer reset value; 3 makes the first search start at source 0
package rr_mux_pkg;

   localparam int N_IN = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam sel_t PTR_RST = 2'd3;

   // One-hot ready vector for a granted source index.
   function automatic logic [N_IN-1:0] onehot(input sel_t idx);
      logic [N_IN-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way grant selection, round-robin or fixed priority
//
// Purpose : picks one requesting source per cycle (purely combinational).
// Config  : RR_MUX_ROUND_ROBIN_EN defined   -> round-robin search starting
//                                              after ptr (ptr+1 .. ptr, mod 4)
//           RR_MUX_ROUND_ROBIN_EN undefined -> lowest index wins, ptr ignored
// Ports   :
//   req   in  [3:0]  per-source request
//   ptr   in  sel_t  index granted by the last accepted transfer
//   grant out sel_t  selected source (meaningful only when any=1)
//   any   out 1      at least one request present
module rr_arbiter_4
   import rr_mux_pkg::*;
(
   input  logic [N_IN-1:0] req,
   input  sel_t            ptr,
   output sel_t            grant,
   output logic            any
);

   assign any = |req;

`ifdef RR_MUX_ROUND_ROBIN_EN

   sel_t idx;
   logic found;

   // Offsets 1..4 wrap through the 2-bit cast, so the last candidate
   // examined is ptr itself: the previous winner has lowest priority.
   always_comb begin
      grant = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 1; k <= N_IN; k++) begin
         idx = ptr + sel_t'(k);
         if (!found && req[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

`else

   // ptr only matters in the round-robin build.
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      grant = 2'd0;
      casez (req)
         4'b???1: grant = 2'd0;
         4'b??10: grant = 2'd1;
         4'b?100: grant = 2'd2;
         4'b1000: grant = 2'd3;
         default: grant = 2'd0;
      endcase
   end

`endif

endmodule

// File: rtl/rr_mux_4x1.sv
// rtl/rr_mux_4x1.sv - 4:1 valid/ready merge with registered output and source tag
//
// Purpose : merges four valid/ready sources into one registered output,
//           sustaining one word per cycle; dout_sel tags each word with its
//           source so a matching 1x4 demux can route it back.
// Config  : RR_MUX_ROUND_ROBIN_EN selects round-robin arbitration
//           (fixed lowest-index priority when undefined).
// Ports   :
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   din        in   4*WIDTH    source data, source i at din[i*WIDTH +: WIDTH]
//   din_valid  in   4          per-source valid
//   din_ready  out  4          per-source ready, at most one bit set
//   dout       out  WIDTH      registered merged data
//   dout_valid out  1          dout holds an unconsumed word
//   dout_ready in   1          downstream accepts dout
//   dout_sel   out  2          source index of the word in dout
module rr_mux_4x1
   import rr_mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*WIDTH-1:0]    din,
   input  logic [N_IN-1:0]       din_valid,
   output logic [N_IN-1:0]       din_ready,
   output logic [WIDTH-1:0]      dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [1:0]            dout_sel
);

   state_t           state;
   state_t           state_nxt;
   sel_t             ptr;
   sel_t             grant;
   logic             any;
   logic             can_load;
   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] din_grant;

   rr_arbiter_4 u_arb (
      .req   (din_valid),
      .ptr   (ptr),
      .grant (grant),
      .any   (any)
   );

   assign din_grant = din[grant*WIDTH +: WIDTH];

   // The output register can take a new word when it is empty, or when the
   // word it holds leaves this same cycle (full throughput).
   assign can_load = (state == EMPTY) || dout_ready;

   // rst_n gating keeps din_ready low for the whole reset assertion even
   // though the register has already been forced EMPTY.
   assign in_xfer   = rst_n && can_load && any;
   assign out_xfer  = (state == FULL) && dout_ready;
   assign din_ready = in_xfer ? onehot(grant) : '0;

   assign dout_valid = (state == FULL);

   always_comb begin
      state_nxt = state;
      if (in_xfer) begin
         state_nxt = FULL;
      end else if (out_xfer) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Data, tag and pointer move only on an accepted input, so a stalled
   // FULL register holds its word and tag unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_sel <= 2'd0;
         ptr      <= PTR_RST;
      end else if (in_xfer) begin
         dout     <= din_grant;
         dout_sel <= grant;
         ptr      <= grant;
      end
   end

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb/tb_rr_mux_4x1.sv - directed self-checking bench for rr_mux_4x1
module tb_rr_mux_4x1;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst_n;
   logic [4*WIDTH-1:0] din;
   logic [3:0]         din_valid;
   logic [3:0]         din_ready;
   logic [WIDTH-1:0]   dout;
   logic               dout_valid;
   logic               dout_ready;
   logic [1:0]         dout_sel;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [3:0] v;
      logic       r;
      logic [3:0] e_rdy;
      logic       e_vld;
      logic [1:0] e_sel;
      logic [7:0] e_dout;
   } vec_t;

   vec_t tbl [8];

   rr_mux_4x1 #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_sel   (dout_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_din(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
      din = {d3, d2, d1, d0};
   endtask

   task automatic set_vec(input int i, input logic [3:0] v, input logic r,
                          input logic [3:0] er, input logic ev,
                          input logic [1:0] es, input logic [7:0] ed);
      tbl[i].v = v;
      tbl[i].r = r;
      tbl[i].e_rdy = er;
      tbl[i].e_vld = ev;
      tbl[i].e_sel = es;
      tbl[i].e_dout = ed;
   endtask

   // Inputs change on the falling edge; one edge later outputs are sampled
   // on the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      din_valid = 4'b0000;
      dout_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      din_valid = 4'b0000;
      dout_ready = 1'b0;
      set_din(8'h10, 8'h11, 8'h12, 8'h13);

`ifdef RR_MUX_ROUND_ROBIN_EN
      set_vec(0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10);
      set_vec(1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
      set_vec(2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12);
      set_vec(3, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12);
      set_vec(4, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13);
      set_vec(5, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13);
      set_vec(6, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13);
      set_vec(7, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13);
`else
      set_vec(0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10);
      set_vec(1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10);
      set_vec(2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12);
      set_vec(3, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12);
      set_vec(4, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
      set_vec(5, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11);
      set_vec(6, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13);
      set_vec(7, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13);
`endif

      // Reset state with every source requesting.
      @(negedge clk);
      din_valid = 4'b1111;
      #1;
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_dout_sel", dout_sel, 2'd0);
      chk("rst_din_ready", din_ready, 4'b0000);
      din_valid = 4'b0000;
      step();
      rst_n = 1'b1;

      // Table of cycle-by-cycle vectors.
      for (int i = 0; i < 8; i++) begin
         din_valid = tbl[i].v;
         dout_ready = tbl[i].r;
         #1;
         chk($sformatf("tbl%0d_din_ready", i), din_ready, tbl[i].e_rdy);
         step();
         chk($sformatf("tbl%0d_dout_valid", i), dout_valid, tbl[i].e_vld);
         chk($sformatf("tbl%0d_dout_sel", i), dout_sel, tbl[i].e_sel);
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      end

      // Single source: drain first, then present only source 2.
      din_valid = 4'b0000;
      dout_ready = 1'b1;
      step();
      set_din(8'h10, 8'h11, 8'h3C, 8'h13);
      din_valid = 4'b0100;
      #1;
      chk("single_din_ready", din_ready, 4'b0100);
      step();
      chk("single_dout", dout, 8'h3C);
      chk("single_dout_sel", dout_sel, 2'd2);
      chk("single_dout_valid", dout_valid, 1'b1);

      // All valid, dout_ready=1 from a fresh reset: one word per cycle.
      do_reset();
      set_din(8'h10, 8'h11, 8'h12, 8'h13);
      din_valid = 4'b1111;
      dout_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         logic [1:0] es;
`ifdef RR_MUX_ROUND_ROBIN_EN
         es = 2'(c % 4);
`else
         es = 2'd0;
`endif
         #1;
         chk($sformatf("stream%0d_din_ready", c), din_ready, 4'b0001 << es);
         step();
         chk($sformatf("stream%0d_dout_sel", c), dout_sel, es);
         chk($sformatf("stream%0d_dout", c), dout, 8'h10 + 8'(es));
         chk($sformatf("stream%0d_dout_valid", c), dout_valid, 1'b1);
      end

      // Backpressure: hold 8'h55 for three stalled cycles.
      do_reset();
      set_din(8'h55, 8'h11, 8'h12, 8'h13);
      din_valid = 4'b0001;
      dout_ready = 1'b1;
      step();
      chk("bp_load_dout", dout, 8'h55);
      set_din(8'h10, 8'h11, 8'h12, 8'h13);
      din_valid = 4'b1111;
      dout_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_din_ready", c), din_ready, 4'b0000);
         step();
         chk($sformatf("bp%0d_dout", c), dout, 8'h55);
         chk($sformatf("bp%0d_dout_valid", c), dout_valid, 1'b1);
      end
      dout_ready = 1'b1;
      #1;
`ifdef RR_MUX_ROUND_ROBIN_EN
      chk("bp_release_din_ready", din_ready, 4'b0010);
`else
      chk("bp_release_din_ready", din_ready, 4'b0001);
`endif
      step();
      chk("bp_release_dout_valid", dout_valid, 1'b1);
`ifdef RR_MUX_ROUND_ROBIN_EN
      chk("bp_release_dout", dout, 8'h11);
`else
      chk("bp_release_dout", dout, 8'h10);
`endif

      // Idle drain: word leaves, nothing replaces it, ptr holds.
      din_valid = 4'b0000;
      dout_ready = 1'b1;
      #1;
      chk("drain_din_ready", din_ready, 4'b0000);
      step();
      chk("drain_dout_valid", dout_valid, 1'b0);
`ifdef RR_MUX_ROUND_ROBIN_EN
      chk("drain_ptr", dut.ptr, 2'd1);
`else
      chk("drain_ptr", dut.ptr, 2'd0);
`endif

      // Reset asserted while FULL with 8'hA5.
      set_din(8'hA5, 8'h11, 8'h12, 8'h13);
      din_valid = 4'b0001;
      step();
      chk("rmid_load_dout", dout, 8'hA5);
      chk("rmid_load_valid", dout_valid, 1'b1);
      set_din(8'h10, 8'h11, 8'h12, 8'h13);
      din_valid = 4'b1111;
      dout_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rmid_dout_valid", dout_valid, 1'b0);
      chk("rmid_dout", dout, 8'h00);
      chk("rmid_dout_sel", dout_sel, 2'd0);
      chk("rmid_din_ready", din_ready, 4'b0000);
      step();
      rst_n = 1'b1;
      dout_ready = 1'b1;
      #1;
      chk("rpost_din_ready", din_ready, 4'b0001);
      step();
      chk("rpost_dout_sel", dout_sel, 2'd0);
      chk("rpost_dout", dout, 8'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
